// File: rtl/sync_up_counter_jk_if.sv
// sync_up_counter_jk_if: control/status bundle for sync_up_counter_jk
//   EN    count enable            LOAD  parallel load strobe
//   D     parallel load value     Q     current count
//   TC    terminal count          OVF   sticky wrap flag
interface sync_up_counter_jk_if #(parameter int WIDTH = 4);
    logic             EN;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             OVF;
    modport master (output EN, LOAD, D, input Q, TC, OVF);
    modport slave (input EN, LOAD, D, output Q, TC, OVF);
endinterface

// File: rtl/sync_up_counter_jk.sv
// sync_up_counter_jk: modulo-MODULUS synchronous up counter built from JK flip-flops
//   CLK  clock, rising edge      RST  synchronous active-high reset
//   bus  slave side of sync_up_counter_jk_if (EN, LOAD, D in; Q, TC, OVF out)
module sync_up_counter_jk #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic                  CLK,
    input logic                  RST,
    sync_up_counter_jk_if.slave  bus
);
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);
    localparam bit POW2 = MODULUS == (1 << WIDTH);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] load_val;
    logic             wrap;
    logic             kill;
    logic             ovf;
    logic             ovf_next;
    always_comb begin
        wrap     = {1'b0, q} >= LAST;
        load_val = {1'b0, bus.D} <= LAST ? bus.D : '0;
        // bit i toggles when enabled and every lower bit is 1
        carry    = '0;
        for (int i = 0; i < WIDTH; i++)
            carry[i] = bus.EN && &(q | ~WIDTH'((1 << i) - 1));
        // non-power-of-two wrap (and illegal-state recovery): clear only the set bits
        kill     = bus.EN && wrap && !POW2;
        j        = RST ? '0 : bus.LOAD ? load_val  : kill ? '0 : carry;
        k        = RST ? '1 : bus.LOAD ? ~load_val : kill ? q  : carry;
        ovf_next = RST || bus.LOAD ? 1'b0 : bus.EN && wrap ? 1'b1 : ovf;
    end
    always_ff @(posedge CLK) begin
        for (int i = 0; i < WIDTH; i++)
            q[i] <= j[i] && k[i] ? ~q[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : q[i];
        ovf <= ovf_next;
    end
    assign bus.Q   = q;
    assign bus.OVF = ovf;
    assign bus.TC  = bus.EN && ({1'b0, q} == LAST);
endmodule

// File: tb/tb_sync_up_counter_jk.sv
// tb_sync_up_counter_jk: random and directed checks of sync_up_counter_jk against an arithmetic model
module tb_sync_up_counter_jk;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sync_up_counter_jk_if #(.WIDTH(4)) a_if ();
    sync_up_counter_jk_if #(.WIDTH(4)) b_if ();
    sync_up_counter_jk_if #(.WIDTH(4)) lo_if ();
    sync_up_counter_jk_if #(.WIDTH(4)) hi_if ();

    sync_up_counter_jk #(.WIDTH(4), .MODULUS(16)) u_a  (.CLK(CLK), .RST(RST), .bus(a_if.slave));
    sync_up_counter_jk #(.WIDTH(4), .MODULUS(10)) u_b  (.CLK(CLK), .RST(RST), .bus(b_if.slave));
    sync_up_counter_jk #(.WIDTH(4), .MODULUS(10)) u_lo (.CLK(CLK), .RST(RST), .bus(lo_if.slave));
    sync_up_counter_jk #(.WIDTH(4), .MODULUS(10)) u_hi (.CLK(CLK), .RST(RST), .bus(hi_if.slave));

    assign lo_if.LOAD = 1'b0;
    assign lo_if.D    = '0;
    assign hi_if.EN   = lo_if.TC;
    assign hi_if.LOAD = 1'b0;
    assign hi_if.D    = '0;

    int n_vec = 0;
    int n_bad = 0;
    int mod_m [2] = '{16, 10};
    int mq [2] = '{0, 0};
    int mo [2] = '{0, 0};
    int bcd = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int dv, input bit ce);
        RST = r;
        a_if.EN = e;   b_if.EN = e;
        a_if.LOAD = l; b_if.LOAD = l;
        a_if.D = 4'(dv); b_if.D = 4'(dv);
        lo_if.EN = ce;
        @(posedge CLK);
        for (int n = 0; n < 2; n++) begin
            if (r) begin
                mq[n] = 0;
                mo[n] = 0;
            end else if (l) begin
                mq[n] = dv < mod_m[n] ? dv : 0;
                mo[n] = 0;
            end else if (e) begin
                if (mq[n] == mod_m[n] - 1) mo[n] = 1;
                mq[n] = (mq[n] + 1) % mod_m[n];
            end
        end
        bcd = r ? 0 : ce ? (bcd + 1) % 100 : bcd;
        #1;
        chk("q16",   int'(a_if.Q),   mq[0]);
        chk("tc16",  int'(a_if.TC),  int'(e && mq[0] == 15));
        chk("ovf16", int'(a_if.OVF), mo[0]);
        chk("q10",   int'(b_if.Q),   mq[1]);
        chk("tc10",  int'(b_if.TC),  int'(e && mq[1] == 9));
        chk("ovf10", int'(b_if.OVF), mo[1]);
        chk("bcd",   int'(hi_if.Q) * 10 + int'(lo_if.Q), bcd);
    endtask

    initial begin
        repeat (2) step(1, 1, 1, 7, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (17) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 6, 0);
        step(0, 0, 1, 12, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 15, 0);
        step(0, 1, 0, 0, 0);
        repeat (15) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (101) step(0, 0, 0, 0, 1);
        repeat (400)
            step($urandom % 32 == 0, $urandom % 2 == 0, $urandom % 8 == 0,
                 int'($urandom % 16), $urandom % 4 != 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
